// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg
//   Shared definitions for the button gesture decoder and the display top level.
//   - state_t        : gesture FSM states
//   - DEFAULT_*      : default timing constants in clk cycles (10 MHz clock)
//   - clog2()        : ceiling log2, used to size counters from time constants
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_LONG_TIME   = 5_000_000;  // 0.5 s
    localparam int DEFAULT_DOUBLE_GAP  = 2_500_000;  // 0.25 s
    localparam int DEFAULT_REPEAT_TIME = 1_000_000;  // 0.1 s

    // Counter must hold the largest terminal value; the long time dominates.
    localparam int DEFAULT_CNT_W = clog2(DEFAULT_LONG_TIME + 1);

endpackage : button_event_decoder_pkg

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns the debounced button level into one-cycle gesture events.
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     btn_db       in   debounced button level, already synchronous to clk
//     short_pulse  out  one-cycle pulse: single short press completed
//     double_pulse out  one-cycle pulse: second press of a double press released
//     long_pulse   out  one-cycle pulse: press has just become long
//     repeat_pulse out  periodic one-cycle pulse while a long press is held
//     held         out  level, high while the FSM is in LONG
//
//   Handshake: none. btn_db is sampled on every rising clk edge; every output
//   is registered on the edge that makes the decision, so a pulse is visible
//   for exactly the cycle following that edge. At most one pulse is high.
//
//   A single counter is shared by all timed states; each state reloads it to
//   zero on entry and compares against its own terminal value, so it never
//   wraps.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_TIME   = DEFAULT_LONG_TIME,
    parameter int DOUBLE_GAP  = DEFAULT_DOUBLE_GAP,
    parameter int REPEAT_TIME = DEFAULT_REPEAT_TIME,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_d, double_d, long_d, repeat_d, held_d;

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            short_pulse  <= short_d;
            double_pulse <= double_d;
            long_pulse   <= long_d;
            repeat_pulse <= repeat_d;
            held         <= held_d;
        end
    end

    // Next-state, counter load/increment and pulse decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_db) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end

            // Release is checked first so a release on the terminal edge
            // suppresses the long pulse.
            ST_PRESS1: begin
                if (!btn_db) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Press is checked first so a press on the terminal edge still
            // counts as the second press of a double.
            ST_GAP: begin
                if (btn_db) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // No timing here: the second press lasts as long as it lasts.
            ST_PRESS2: begin
                if (!btn_db) begin
                    state_d  = ST_IDLE;
                    double_d = 1'b1;
                end
            end

            ST_LONG: begin
                if (!btn_db) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_LONG);
    end

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder
//   Directed bench for button_event_decoder with small timing parameters
//   (LONG_TIME=8, DOUBLE_GAP=4, REPEAT_TIME=3, CNT_W=4).
//   Each tick() applies one btn_db level, waits for the rising edge and
//   settles 1 ns; the registered outputs are then compared as a packed
//   vector {short, double, long, repeat, held}.
module tb_button_event_decoder;

    localparam int LONG_TIME   = 8;
    localparam int DOUBLE_GAP  = 4;
    localparam int REPEAT_TIME = 3;
    localparam int CNT_W       = 4;

    // Expected output vectors {short, double, long, repeat, held}.
    localparam logic [4:0] NONE   = 5'b00000;
    localparam logic [4:0] SHORT  = 5'b10000;
    localparam logic [4:0] DOUBLE = 5'b01000;
    localparam logic [4:0] HELD   = 5'b00001;

    logic clk;
    logic rst_n;
    logic btn_db;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    int check_cnt;
    int pass_cnt;
    int fail_cnt;

    button_event_decoder #(
        .LONG_TIME  (LONG_TIME),
        .DOUBLE_GAP (DOUBLE_GAP),
        .REPEAT_TIME(REPEAT_TIME),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_db      (btn_db),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed  = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
        check_cnt = check_cnt + 1;
        assert (observed === expected)
            pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed {s,d,l,r,h}=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic tick(input logic b);
        btn_db = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input logic b, input string tag, input logic [4:0] expected);
        tick(b);
        check(tag, expected);
    endtask

    initial begin
        logic [4:0] exp_v;
        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        rst_n     = 1'b0;
        btn_db    = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        check("reset", NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_chk(1'b0, "idle_after_reset", NONE);

        // Short press: high 3 edges, release, short 4 edges after release.
        tick_chk(1'b1, "short_e0", NONE);
        tick_chk(1'b1, "short_hi1", NONE);
        tick_chk(1'b1, "short_hi2", NONE);
        tick_chk(1'b0, "short_rel", NONE);
        tick_chk(1'b0, "short_gap1", NONE);
        tick_chk(1'b0, "short_gap2", NONE);
        tick_chk(1'b0, "short_gap3", NONE);
        tick_chk(1'b0, "short_fire", SHORT);
        tick_chk(1'b0, "short_after", NONE);

        // Double press: high 2, low 2, high 2, low.
        tick_chk(1'b1, "dbl_e0", NONE);
        tick_chk(1'b1, "dbl_hi1", NONE);
        tick_chk(1'b0, "dbl_rel1", NONE);
        tick_chk(1'b0, "dbl_gap1", NONE);
        tick_chk(1'b1, "dbl_press2", NONE);
        tick_chk(1'b1, "dbl_hi2", NONE);
        tick_chk(1'b0, "dbl_fire", DOUBLE);
        for (int i = 0; i < 5; i++) tick_chk(1'b0, "dbl_no_short", NONE);

        // Long press with repeat: edge E0+i for i = 0..20.
        for (int i = 0; i <= 20; i++) begin
            exp_v    = NONE;
            exp_v[2] = (i == 8);
            exp_v[1] = (i > 8) && (((i - 8) % 3) == 0);
            exp_v[0] = (i >= 8);
            tick_chk(1'b1, $sformatf("long_e%0d", i), exp_v);
        end
        tick_chk(1'b0, "long_release", NONE);
        for (int i = 0; i < 6; i++) tick_chk(1'b0, "long_after_rel", NONE);

        // Long-boundary tie: release sampled on E0+8.
        for (int i = 0; i < 8; i++) tick_chk(1'b1, "ltie_hold", NONE);
        tick_chk(1'b0, "ltie_rel_no_long", NONE);
        tick_chk(1'b0, "ltie_gap1", NONE);
        tick_chk(1'b0, "ltie_gap2", NONE);
        tick_chk(1'b0, "ltie_gap3", NONE);
        tick_chk(1'b0, "ltie_short", SHORT);
        tick_chk(1'b0, "ltie_after", NONE);

        // Gap-boundary tie: second press sampled on 4th GAP edge.
        tick_chk(1'b1, "gtie_e0", NONE);
        tick_chk(1'b1, "gtie_hi1", NONE);
        tick_chk(1'b0, "gtie_rel", NONE);
        tick_chk(1'b0, "gtie_gap1", NONE);
        tick_chk(1'b0, "gtie_gap2", NONE);
        tick_chk(1'b0, "gtie_gap3", NONE);
        tick_chk(1'b1, "gtie_press_no_short", NONE);
        tick_chk(1'b1, "gtie_hi2", NONE);
        tick_chk(1'b0, "gtie_double", DOUBLE);
        tick_chk(1'b0, "gtie_after", NONE);

        // Reset during GAP discards the pending short press.
        tick_chk(1'b1, "rgap_e0", NONE);
        tick_chk(1'b0, "rgap_rel", NONE);
        tick_chk(1'b0, "rgap_gap1", NONE);
        rst_n = 1'b0;
        #1;
        check("rgap_in_reset", NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick_chk(1'b0, "rgap_no_pulse", NONE);

        // Reset while held in LONG with the button still down.
        for (int i = 0; i < 8; i++) tick_chk(1'b1, "rlong_pre", NONE);
        tick_chk(1'b1, "rlong_long", 5'b00101);
        tick_chk(1'b1, "rlong_held", HELD);
        rst_n = 1'b0;
        #1;
        check("rlong_in_reset", NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            exp_v    = NONE;
            exp_v[2] = (i == 8);
            exp_v[0] = (i == 8);
            tick_chk(1'b1, $sformatf("rlong_re_e%0d", i), exp_v);
        end
        tick_chk(1'b0, "rlong_release", NONE);
        tick_chk(1'b0, "rlong_after", NONE);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_button_event_decoder
